// File: rtl/uart_proto_pkg.sv
// Shared definitions for the board UART control protocol, used by the host
// sequencer and the control unit.
package uart_proto_pkg;

  localparam logic [7:0] CFG_HDR   = 8'hA5;
  localparam logic [7:0] START_CMD = 8'h5A;
  localparam logic [7:0] RESP_HDR  = 8'hC3;

  // Response payload: two 64-bit MSE values, little-endian, set 0 first.
  localparam int RESP_BYTES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_HDR,
    ST_RECV,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  // Two frac-width sets, one byte per channel each.
  function automatic int cfg_byte_count(input int num_chan);
    return 2 * num_chan;
  endfunction

endpackage

// File: rtl/uart_host_sequencer_tx_pacer.sv
// Transmit pacer: registers one byte per request and reports ready once
// BYTE_GAP cycles have elapsed since the previous strobe.
module tx_pacer #(
  parameter int BYTE_GAP = 8700
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  output logic       com_txvalid_o,
  output logic [7:0] com_txdata_o,
  output logic       ready_o
);

  localparam int GAP_W = (BYTE_GAP > 2) ? $clog2(BYTE_GAP) : 1;

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             vld_q, vld_d;
  logic [7:0]       data_q, data_d;

  always_comb begin
    vld_d  = req_i;
    data_d = data_q;
    gap_d  = gap_q;
    if (req_i) begin
      data_d = byte_i;
      // Loading GAP-1 makes ready rise on the last cycle before the next slot.
      gap_d  = GAP_W'(BYTE_GAP - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      gap_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      gap_q  <= gap_d;
    end
  end

  assign ready_o       = (gap_q == '0);
  assign com_txvalid_o = vld_q;
  assign com_txdata_o  = data_q;

endmodule

// File: rtl/uart_host_sequencer.sv
// Host-side UART protocol sequencer: sends the frac configuration and start
// command, then collects the two 64-bit MSE results from the control unit.
module uart_host_sequencer
  import uart_proto_pkg::*;
#(
  parameter int NUM_CHAN = 3,
  parameter int BYTE_GAP = 8700,
  parameter int TIMEOUT  = 16777216
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    go,
  input  logic [16*NUM_CHAN-1:0]  cfg_frac,
  output logic                    com_txvalid,
  output logic [7:0]              com_txdata,
  input  logic                    com_rxvalid,
  input  logic [7:0]              com_rxdata,
  output logic                    busy,
  output logic [63:0]             mse0,
  output logic [63:0]             mse1,
  output logic                    result_valid,
  output logic                    timeout_err
);

  localparam int NCFG  = cfg_byte_count(NUM_CHAN);
  localparam int NTX   = NCFG + 2;
  localparam int IDX_W = $clog2(NTX);
  localparam int TMO_W = $clog2(TIMEOUT);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [8*NCFG-1:0]  cfg_q, cfg_d;
  logic [119:0]       sh_q, sh_d;
  logic [3:0]         rcnt_q, rcnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [63:0]        mse0_q, mse0_d;
  logic [63:0]        mse1_q, mse1_d;
  logic               tx_req;
  logic [7:0]         tx_byte;
  logic               tx_ready;
  logic               tmo_expired;

  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cfg_d   = cfg_q;
    sh_d    = sh_q;
    rcnt_d  = rcnt_q;
    tmo_d   = '0;
    mse0_d  = mse0_q;
    mse1_d  = mse1_q;
    tx_req  = 1'b0;
    tx_byte = cfg_q[7:0];
    case (state_q)
      ST_IDLE: begin
        // Header goes out immediately; the config is captured on the same edge.
        if (go) begin
          tx_req  = 1'b1;
          tx_byte = CFG_HDR;
          cfg_d   = cfg_frac;
          idx_d   = IDX_W'(1);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_req = 1'b1;
          if (idx_q == IDX_W'(NTX - 1)) begin
            tx_byte = START_CMD;
            idx_d   = '0;
            state_d = ST_WAIT_HDR;
          end else begin
            cfg_d = cfg_q >> 8;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT_HDR: begin
        if (com_rxvalid) begin
          if (com_rxdata == RESP_HDR) begin
            rcnt_d  = '0;
            state_d = ST_RECV;
          end
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RECV: begin
        // The first 15 bytes are held; the 16th is merged straight into the results.
        if (com_rxvalid) begin
          rcnt_d = rcnt_q + 4'd1;
          sh_d   = {com_rxdata, sh_q[119:8]};
          if (rcnt_q == 4'(RESP_BYTES - 1)) begin
            {mse1_d, mse0_d} = {com_rxdata, sh_q};
            state_d          = ST_DONE;
          end
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cfg_q   <= '0;
      sh_q    <= '0;
      rcnt_q  <= '0;
      tmo_q   <= '0;
      mse0_q  <= '0;
      mse1_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      sh_q    <= sh_d;
      rcnt_q  <= rcnt_d;
      tmo_q   <= tmo_d;
      mse0_q  <= mse0_d;
      mse1_q  <= mse1_d;
    end
  end

  tx_pacer #(
    .BYTE_GAP(BYTE_GAP)
  ) u_tx_pacer (
    .clk          (clk),
    .rstn         (rstn),
    .req_i        (tx_req),
    .byte_i       (tx_byte),
    .com_txvalid_o(com_txvalid),
    .com_txdata_o (com_txdata),
    .ready_o      (tx_ready)
  );

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign timeout_err  = (state_q == ST_ERR);
  assign mse0         = mse0_q;
  assign mse1         = mse1_q;

endmodule
